// File: rtl/vga_scan_timer.sv
// VGA raster timer: pixel-rate enable, scan counters, syncs and frame tick.
// Default geometry is 640x480 @ 60 Hz from a 50 MHz clock.
module vga_scan_timer #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic       vga_clk,
  output logic [9:0] hs,
  output logic [9:0] vs,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL =
    H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] HS_ON   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_OFF  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_OFF  = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       div_q;
  logic [9:0] hs_q, hs_d;
  logic [9:0] vs_q, vs_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       video_on_q, video_on_d;

  always_comb begin
    hs_d = hs_q;
    vs_d = vs_q;
    if (div_q) begin
      if (hs_q == H_LAST) begin
        hs_d = '0;
        if (vs_q == V_LAST) begin
          vs_d = '0;
        end else begin
          vs_d = vs_q + 10'd1;
        end
      end else begin
        hs_d = hs_q + 10'd1;
      end
    end
  end

  // Decode the next counter values so syncs line up with hs/vs.
  always_comb begin
    hsync_n_d  = !((hs_d >= HS_ON) && (hs_d < HS_OFF));
    vsync_n_d  = !((vs_d >= VS_ON) && (vs_d < VS_OFF));
    video_on_d = (hs_d < H_VIS) && (vs_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= 1'b0;
      hs_q       <= '0;
      vs_q       <= '0;
      hsync_n_q  <= 1'b1;
      vsync_n_q  <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      div_q      <= ~div_q;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      hsync_n_q  <= hsync_n_d;
      vsync_n_q  <= vsync_n_d;
      video_on_q <= video_on_d;
    end
  end

  assign pix_en     = div_q;
  assign vga_clk    = div_q;
  assign hs         = hs_q;
  assign vs         = vs_q;
  assign hsync_n    = hsync_n_q;
  assign vsync_n    = vsync_n_q;
  assign video_on   = video_on_q;
  assign frame_tick = div_q && (hs_q == H_LAST)
                      && (vs_q == V_LAST);

endmodule

// File: tb/tb_vga_scan_timer.sv
// Directed bench: full-size timer for line pacing, a shrunken
// geometry (25x19) for whole-frame, tick and range scenarios.
module tb_vga_scan_timer;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic rst_s = 1'b0;

  logic       b_pix_en, b_vga_clk, b_hsync_n, b_vsync_n;
  logic       b_video_on, b_frame_tick;
  logic [9:0] b_hs, b_vs;
  logic       s_pix_en, s_vga_clk, s_hsync_n, s_vsync_n;
  logic       s_video_on, s_frame_tick;
  logic [9:0] s_hs, s_vs;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vga_scan_timer u_big (
    .clk(clk), .rst(rst_b),
    .pix_en(b_pix_en), .vga_clk(b_vga_clk),
    .hs(b_hs), .vs(b_vs),
    .hsync_n(b_hsync_n), .vsync_n(b_vsync_n),
    .video_on(b_video_on), .frame_tick(b_frame_tick)
  );

  vga_scan_timer #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_sm (
    .clk(clk), .rst(rst_s),
    .pix_en(s_pix_en), .vga_clk(s_vga_clk),
    .hs(s_hs), .vs(s_vs),
    .hsync_n(s_hsync_n), .vsync_n(s_vsync_n),
    .video_on(s_video_on), .frame_tick(s_frame_tick)
  );

  task automatic reset_both(input int cyc);
    @(negedge clk);
    rst_b = 1'b1;
    rst_s = 1'b1;
    repeat (cyc) @(negedge clk);
    rst_b = 1'b0;
    rst_s = 1'b0;
  endtask

  task automatic test_reset;
    logic [5:0] fb, fs;
    reset_both(3);
    fb = {b_pix_en, b_vga_clk, b_hsync_n, b_vsync_n,
          b_video_on, b_frame_tick};
    fs = {s_pix_en, s_vga_clk, s_hsync_n, s_vsync_n,
          s_video_on, s_frame_tick};
    checks++;
    if ({b_hs, b_vs} !== 20'd0)
      $display("FAIL reset_big_cnt: hs=%0d vs=%0d want 0 0",
               b_hs, b_vs);
    else passed++;
    checks++;
    if (fb !== 6'b001110)
      $display("FAIL reset_big_flags: got %b want 001110", fb);
    else passed++;
    checks++;
    if ({s_hs, s_vs} !== 20'd0)
      $display("FAIL reset_sm_cnt: hs=%0d vs=%0d want 0 0",
               s_hs, s_vs);
    else passed++;
    checks++;
    if (fs !== 6'b001110)
      $display("FAIL reset_sm_flags: got %b want 001110", fs);
    else passed++;
    @(negedge clk);
    checks++;
    if ({b_pix_en, b_vga_clk, s_pix_en} !== 3'b111)
      $display("FAIL reset_pix_en: got %b want 111",
               {b_pix_en, b_vga_clk, s_pix_en});
    else passed++;
    checks++;
    if (b_hs !== 10'd0)
      $display("FAIL reset_hs_hold: got %0d want 0", b_hs);
    else passed++;
    @(negedge clk);
    checks++;
    if (b_hs !== 10'd1 || b_pix_en !== 1'b0)
      $display("FAIL reset_hs_step: hs=%0d pix=%b want 1 0",
               b_hs, b_pix_en);
    else passed++;
  endtask

  task automatic test_h_pacing;
    int hlow = 0;
    int bad = 0;
    reset_both(1);
    for (int n = 1; n <= 1600; n++) begin
      @(negedge clk);
      if (!b_hsync_n) hlow++;
      if (b_hsync_n !== !(b_hs >= 656 && b_hs <= 751)) bad++;
      if (n < 1600 && b_hs !== 10'(n / 2)) bad++;
      if (n == 1278) begin
        checks++;
        if (b_hs !== 10'd639 || b_video_on !== 1'b1)
          $display("FAIL h_639: hs=%0d von=%b want 639 1",
                   b_hs, b_video_on);
        else passed++;
      end
      if (n == 1279) begin
        checks++;
        if (b_hs !== 10'd639 || b_video_on !== 1'b1)
          $display("FAIL h_639_hold: hs=%0d von=%b want 639 1",
                   b_hs, b_video_on);
        else passed++;
      end
      if (n == 1280) begin
        checks++;
        if (b_hs !== 10'd640 || b_video_on !== 1'b0)
          $display("FAIL h_640: hs=%0d von=%b want 640 0",
                   b_hs, b_video_on);
        else passed++;
      end
      if (n == 1599) begin
        checks++;
        if (b_hs !== 10'd799 || b_vs !== 10'd0)
          $display("FAIL h_799: hs=%0d vs=%0d want 799 0",
                   b_hs, b_vs);
        else passed++;
      end
      if (n == 1600) begin
        checks++;
        if (b_hs !== 10'd0 || b_vs !== 10'd1
            || b_video_on !== 1'b1)
          $display("FAIL h_wrap: hs=%0d vs=%0d von=%b want 0 1 1",
                   b_hs, b_vs, b_video_on);
        else passed++;
      end
    end
    checks++;
    if (hlow != 192)
      $display("FAIL h_sync_width: got %0d want 192", hlow);
    else passed++;
    checks++;
    if (bad != 0)
      $display("FAIL h_decode: %0d bad cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_vertical;
    int vid = 0;
    int vlow = 0;
    int bad = 0;
    reset_both(1);
    for (int n = 1; n <= 950; n++) begin
      @(negedge clk);
      if (s_pix_en && s_video_on) vid++;
      if (!s_vsync_n) vlow++;
      if (s_vs >= 12 && s_video_on) bad++;
      if (s_vsync_n !== !(s_vs >= 14 && s_vs <= 15)) bad++;
    end
    checks++;
    if (vid != 192)
      $display("FAIL v_active_px: got %0d want 192", vid);
    else passed++;
    checks++;
    if (vlow != 100)
      $display("FAIL v_sync_width: got %0d want 100", vlow);
    else passed++;
    checks++;
    if (bad != 0)
      $display("FAIL v_decode: %0d bad cycles want 0", bad);
    else passed++;
    checks++;
    if (s_hs !== 10'd0 || s_vs !== 10'd0)
      $display("FAIL v_wrap: hs=%0d vs=%0d want 0 0", s_hs, s_vs);
    else passed++;
  endtask

  task automatic test_frame_tick;
    int ticks = 0;
    int first = -1;
    int last = -1;
    int gapbad = 0;
    int ctxbad = 0;
    logic prev = 1'b0;
    reset_both(1);
    for (int n = 1; n <= 2860; n++) begin
      @(negedge clk);
      if (prev && (s_hs !== 10'd0 || s_vs !== 10'd0
                   || s_frame_tick !== 1'b0)) ctxbad++;
      if (s_frame_tick) begin
        ticks++;
        if (!(s_hs == 10'd24 && s_vs == 10'd18 && s_pix_en))
          ctxbad++;
        if (last >= 0 && n - last != 950) gapbad++;
        if (first < 0) first = n;
        last = n;
      end
      prev = s_frame_tick;
    end
    checks++;
    if (ticks != 3)
      $display("FAIL tick_count: got %0d want 3", ticks);
    else passed++;
    checks++;
    if (first != 949)
      $display("FAIL tick_first: got %0d want 949", first);
    else passed++;
    checks++;
    if (gapbad != 0)
      $display("FAIL tick_period: %0d bad gaps want 0", gapbad);
    else passed++;
    checks++;
    if (ctxbad != 0)
      $display("FAIL tick_context: %0d bad want 0", ctxbad);
    else passed++;
  endtask

  task automatic test_midframe_reset;
    logic [5:0] f;
    reset_both(1);
    repeat (801) @(negedge clk);
    checks++;
    if (b_hs !== 10'd400 || b_pix_en !== 1'b1)
      $display("FAIL mid_big_pre: hs=%0d pix=%b want 400 1",
               b_hs, b_pix_en);
    else passed++;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    f = {b_pix_en, b_vga_clk, b_hsync_n, b_vsync_n,
         b_video_on, b_frame_tick};
    checks++;
    if ({b_hs, b_vs} !== 20'd0 || f !== 6'b001110)
      $display("FAIL mid_big_rst: hs=%0d vs=%0d fl=%b want 0 0 001110",
               b_hs, b_vs, f);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (b_hs !== 10'd1)
      $display("FAIL mid_big_resume: hs=%0d want 1", b_hs);
    else passed++;
    reset_both(1);
    repeat (271) @(negedge clk);
    checks++;
    if (s_hs !== 10'd10 || s_vs !== 10'd5 || s_pix_en !== 1'b1)
      $display("FAIL mid_sm_pre: hs=%0d vs=%0d pix=%b want 10 5 1",
               s_hs, s_vs, s_pix_en);
    else passed++;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    f = {s_pix_en, s_vga_clk, s_hsync_n, s_vsync_n,
         s_video_on, s_frame_tick};
    checks++;
    if ({s_hs, s_vs} !== 20'd0 || f !== 6'b001110)
      $display("FAIL mid_sm_rst: hs=%0d vs=%0d fl=%b want 0 0 001110",
               s_hs, s_vs, f);
    else passed++;
    @(negedge clk);
    checks++;
    if (s_pix_en !== 1'b1 || s_hs !== 10'd0)
      $display("FAIL mid_sm_resume: pix=%b hs=%0d want 1 0",
               s_pix_en, s_hs);
    else passed++;
  endtask

  task automatic test_range;
    int rng = 0;
    int bad = 0;
    int rstbad = 0;
    int pulses = 0;
    logic did = 1'b0;
    logic [5:0] f;
    reset_both(1);
    for (int n = 1; n <= 4750; n++) begin
      @(negedge clk);
      f = {s_pix_en, s_vga_clk, s_hsync_n, s_vsync_n,
           s_video_on, s_frame_tick};
      if (did && ({s_hs, s_vs} !== 20'd0 || f !== 6'b001110))
        rstbad++;
      if (s_hs > 10'd24 || s_vs > 10'd18) rng++;
      if (s_hsync_n !== !(s_hs >= 18 && s_hs <= 21)) bad++;
      if (s_vsync_n !== !(s_vs >= 14 && s_vs <= 15)) bad++;
      if (s_video_on !== (s_hs < 16 && s_vs < 12)) bad++;
      did = ($urandom_range(0, 399) == 0);
      if (did) pulses++;
      rst_s = did;
    end
    rst_s = 1'b0;
    checks++;
    if (rng != 0)
      $display("FAIL range: %0d out-of-range cycles want 0", rng);
    else passed++;
    checks++;
    if (bad != 0)
      $display("FAIL range_decode: %0d bad want 0", bad);
    else passed++;
    checks++;
    if (rstbad != 0)
      $display("FAIL range_rst: %0d of %0d pulses bad want 0",
               rstbad, pulses);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_h_pacing();
    test_vertical();
    test_frame_tick();
    test_midframe_reset();
    test_range();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
